// File: rtl/serial_byte_tx_pkg.sv
// Shared types and constants for the serial byte transmitter and its FIFO.
package serial_byte_tx_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned GAP_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/serial_byte_tx_if.sv
// Parallel-in handshake and serial-out framing signals of serial_byte_tx.
interface serial_byte_tx_if #(
    parameter int unsigned DEPTH = 4
);
    import serial_byte_tx_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [BYTE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              wra_n;
    logic              da;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output din, din_valid,
        input  din_ready, wra_n, da, busy, fifo_count
    );

    modport slave (
        input  din, din_valid,
        output din_ready, wra_n, da, busy, fifo_count
    );

endinterface

// File: rtl/serial_byte_tx_fifo.sv
// Synchronous show-ahead byte FIFO; head is the registered entry at the read pointer.
module sync_byte_fifo
    import serial_byte_tx_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PTR_W wide, so natural overflow gives the modulo-DEPTH wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Buffers parallel bytes and shifts each out MSB first on da, framed by active-low wra_n,
// with GAP_CYCLES idle cycles between frames.
module serial_byte_tx
    import serial_byte_tx_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic            clka,
    input  logic            rst,
    serial_byte_tx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    tx_state_e              state_q, state_d;
    logic [BYTE_W-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   wra_n_q, wra_n_d;
    logic                   da_q, da_d;

    logic                   fifo_pop, fifo_full, fifo_empty, load;
    logic [BYTE_W-1:0]      fifo_head;
    logic [CNT_W-1:0]       fifo_count;

    sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clka),
        .rst       (rst),
        .push      (bus.din_valid),
        .push_data (bus.din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.din_ready  = !fifo_full;
    assign bus.wra_n      = wra_n_q;
    assign bus.da         = da_q;
    assign bus.busy       = !fifo_empty || (state_q != ST_IDLE);
    assign bus.fifo_count = fifo_count;

    // Every path that starts a frame funnels through 'load' so the pop and bit 7 share one edge.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        wra_n_d   = 1'b1;
        da_d      = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                    da_d      = shreg_q[BYTE_W-2];
                    wra_n_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                end else if (GAP_CYCLES > 0) begin
                    gap_cnt_d = GAP_W'(GAP_CYCLES);
                    state_d   = ST_GAP;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    load    = !fifo_empty;
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop  = 1'b1;
            shreg_d   = fifo_head;
            da_d      = fifo_head[BYTE_W-1];
            wra_n_d   = 1'b0;
            bit_cnt_d = '1;
            state_d   = ST_SHIFT;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            wra_n_q   <= 1'b1;
            da_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            wra_n_q   <= wra_n_d;
            da_q      <= da_d;
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: two instances (GAP_CYCLES=1 and 0) share stimulus,
// each frame's byte and start cycle are predicted when the byte is accepted.
module tb_serial_byte_tx;

    localparam int unsigned DEPTH = 4;
    localparam int G0 = 1;
    localparam int G1 = 0;

    logic       clka;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    serial_byte_tx_if #(.DEPTH(DEPTH)) bus0 ();
    serial_byte_tx_if #(.DEPTH(DEPTH)) bus1 ();

    assign bus0.din       = din;
    assign bus0.din_valid = din_valid;
    assign bus1.din       = din;
    assign bus1.din_valid = din_valid;

    serial_byte_tx #(.DEPTH(DEPTH), .GAP_CYCLES(G0)) dut0 (.clka(clka), .rst(rst), .bus(bus0));
    serial_byte_tx #(.DEPTH(DEPTH), .GAP_CYCLES(G1)) dut1 (.clka(clka), .rst(rst), .bus(bus1));

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: per instance, accepted bytes with their predicted frame start cycle.
    logic [7:0] exp_byte  [2][1024];
    int         exp_start [2][1024];
    int         n_push    [2];
    int         n_started [2];
    int         n_checked [2];
    int         last_start[2];
    int         ls        [2];
    bit         have_ls   [2];

    int         bitc [2];
    int         fst  [2];
    logic [7:0] shv  [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? G0 : G1;
    endfunction

    // sel: 0 wra_n, 1 da, 2 din_ready, 3 busy, 4 fifo_count
    function automatic logic [31:0] obs(input int k, input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            0: r = 32'(k == 0 ? bus0.wra_n      : bus1.wra_n);
            1: r = 32'(k == 0 ? bus0.da         : bus1.da);
            2: r = 32'(k == 0 ? bus0.din_ready  : bus1.din_ready);
            3: r = 32'(k == 0 ? bus0.busy       : bus1.busy);
            default: r = 32'(k == 0 ? bus0.fifo_count : bus1.fifo_count);
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h expected=%0h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: samples 1ns after each edge, assembles frames and pops the scoreboard.
    initial begin
        logic [31:0] w, d;
        for (int k = 0; k < 2; k++) begin
            bitc[k] = 0; fst[k] = 0; shv[k] = '0; n_checked[k] = 0;
        end
        forever begin
            @(posedge clka);
            #1;
            for (int k = 0; k < 2; k++) begin
                w = obs(k, 0);
                d = obs(k, 1);
                if (rst) begin
                    chk("rst_wra_n", k, w, 1);
                    chk("rst_da", k, d, 0);
                    chk("rst_din_ready", k, obs(k, 2), 1);
                    chk("rst_busy", k, obs(k, 3), 0);
                    chk("rst_fifo_count", k, obs(k, 4), 0);
                    bitc[k] = 0;
                    n_checked[k] = 0;
                end else if (w == 0) begin
                    if (bitc[k] == 0) fst[k] = cyc;
                    shv[k] = {shv[k][6:0], d[0]};
                    bitc[k]++;
                    if (bitc[k] == 8) begin
                        bitc[k] = 0;
                        chk("frame_expected", k, 32'(n_checked[k] < n_push[k]), 1);
                        if (n_checked[k] < n_push[k]) begin
                            chk("frame_byte", k, 32'(shv[k]), 32'(exp_byte[k][n_checked[k]]));
                            chk("frame_start", k, fst[k], exp_start[k][n_checked[k]]);
                            n_checked[k]++;
                        end
                    end
                end else begin
                    chk("idle_da", k, d, 0);
                    chk("frame_len", k, bitc[k], 0);
                    bitc[k] = 0;
                end
            end
        end
    end

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            n_push[k] = 0; n_started[k] = 0; have_ls[k] = 0;
            last_start[k] = -100; ls[k] = -100;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (n) @(negedge clka);
        rst = 1'b0;
        model_clear();
    endtask

    // Called at the negedge after edge t; drives the inputs seen at edge t+1.
    task automatic step(input logic v, input logic [7:0] d, output logic [1:0] acc);
        int t, cnt, s, g;
        bit bz;
        t = cyc;
        acc = '0;
        for (int k = 0; k < 2; k++) begin
            g = gap_of(k);
            while (n_started[k] < n_push[k] && exp_start[k][n_started[k]] <= t) begin
                ls[k] = exp_start[k][n_started[k]];
                have_ls[k] = 1;
                n_started[k]++;
            end
            cnt = n_push[k] - n_started[k];
            bz = (cnt > 0) || (have_ls[k] && t <= ls[k] + 7 + g);
            chk("fifo_count", k, obs(k, 4), cnt);
            chk("din_ready", k, obs(k, 2), 32'(cnt < int'(DEPTH)));
            chk("busy", k, obs(k, 3), 32'(bz));
            if (v && cnt < int'(DEPTH)) begin
                acc[k] = 1'b1;
                s = (t + 2 > last_start[k] + 8 + g) ? t + 2 : last_start[k] + 8 + g;
                exp_byte[k][n_push[k]]  = d;
                exp_start[k][n_push[k]] = s;
                last_start[k] = s;
                n_push[k]++;
            end
        end
        din = d;
        din_valid = v;
        @(negedge clka);
    endtask

    task automatic idle(input int n);
        logic [1:0] a;
        repeat (n) step(1'b0, 8'h00, a);
    endtask

    initial begin
        logic [1:0] acc;
        logic [7:0] nb;
        logic [7:0] seq3 [3];
        din = '0;
        din_valid = 1'b0;
        model_clear();
        do_reset(2);

        // Single byte 0xA5.
        step(1'b1, 8'hA5, acc);
        idle(20);

        // Three back-to-back bytes; second push coincides with the first pop.
        seq3[0] = 8'h3C; seq3[1] = 8'hFF; seq3[2] = 8'h00;
        for (int i = 0; i < 3; i++) step(1'b1, seq3[i], acc);
        idle(60);

        // Continuous supply of incrementing bytes until the FIFO fills.
        nb = 8'h01;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, nb, acc);
            if (acc[0]) nb = nb + 8'h01;
        end
        idle(60);

        // Back-to-back frames for the zero-gap instance.
        step(1'b1, 8'h81, acc);
        step(1'b1, 8'h7E, acc);
        idle(40);

        // Reset while bit 3 of the first frame is on da with two bytes still queued.
        seq3[0] = 8'hC3; seq3[1] = 8'h5A; seq3[2] = 8'h96;
        for (int i = 0; i < 3; i++) step(1'b1, seq3[i], acc);
        idle(3);
        do_reset(1);
        idle(30);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'b1 && ($urandom_range(0, 99) < 45), 8'($urandom), acc);
        end
        idle(80);

        for (int k = 0; k < 2; k++) begin
            chk("all_frames_seen", k, n_checked[k], n_push[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
